// File: rtl/dl_ram_arbiter.sv
// dl_ram_arbiter: shares the single RAM port between the CPU bus and the
// download writer, buffering un-stallable download strobes in a small FIFO.
module dl_ram_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        downloading,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [24:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [7:0]  cpu_dout,
    output logic        ram_req,
    output logic        ram_we,
    output logic [24:0] ram_addr,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    input  logic        ram_ack,
    output logic        dl_busy,
    output logic        dl_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DL_ACC  = 2'd1;
    localparam logic [1:0] CPU_ACC = 2'd2;

    logic [1:0]    state;
    logic [32:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          last_dl;
    logic          downloading_q;

    logic        dl_pend;
    logic        cpu_pend;
    logic        fifo_full;
    logic        near_full;
    logic        grant_dl;
    logic        grant_cpu;
    logic        push;
    logic        pop;
    logic [32:0] head;

    assign head      = fifo_mem[rd_ptr];
    assign dl_pend   = (count != '0);
    // The request is still high in the cpu_ack cycle; it is already served.
    assign cpu_pend  = cpu_req & ~cpu_ack;
    assign fifo_full = count[AW];
    assign near_full = count[AW] | (&count[AW-1:0]);

    always_comb begin
        grant_dl  = 1'b0;
        grant_cpu = 1'b0;
        if (state == IDLE) begin
            if (dl_pend && cpu_pend) begin
                grant_dl  = near_full | ~last_dl;
                grant_cpu = ~grant_dl;
            end else begin
                grant_dl  = dl_pend;
                grant_cpu = cpu_pend;
            end
        end
    end

    assign pop     = grant_dl;
    assign push    = dl_wr & (~fifo_full | pop);
    assign dl_busy = downloading | dl_pend | (state == DL_ACC);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {dl_addr, dl_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            ram_req       <= 1'b0;
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            ram_din       <= '0;
            cpu_ack       <= 1'b0;
            cpu_dout      <= '0;
            dl_overflow   <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            last_dl       <= 1'b0;
            downloading_q <= 1'b0;
        end else begin
            downloading_q <= downloading;
            cpu_ack       <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end

            if (dl_wr && fifo_full && !pop) begin
                dl_overflow <= 1'b1;
            end else if (downloading && !downloading_q) begin
                dl_overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (grant_dl) begin
                        state    <= DL_ACC;
                        ram_req  <= 1'b1;
                        ram_we   <= 1'b1;
                        ram_addr <= head[32:8];
                        ram_din  <= head[7:0];
                        last_dl  <= 1'b1;
                    end else if (grant_cpu) begin
                        state    <= CPU_ACC;
                        ram_req  <= 1'b1;
                        ram_we   <= cpu_we;
                        ram_addr <= cpu_addr;
                        ram_din  <= cpu_din;
                        last_dl  <= 1'b0;
                    end
                end
                DL_ACC, CPU_ACC: begin
                    if (ram_ack) begin
                        state   <= IDLE;
                        ram_req <= 1'b0;
                        if (state == CPU_ACC) begin
                            cpu_ack <= 1'b1;
                            if (!ram_we) begin
                                cpu_dout <= ram_dout;
                            end
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    ram_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
